// File: rtl/i2s_seq_pkg.sv
// Shared types for the I2S capture sequencer: FSM state encoding and capture modes.
package i2s_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FLUSH,
        ARM,
        CAPT,
        HANG,
        DRAIN,
        DONE
    } state_t;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_VAD   = 1'b1;

endpackage

// File: rtl/i2s_seq_obuf.sv
// One-entry output register for the capture stream; data and last are held
// stable while a beat is pending and the consumer is not ready.
module i2s_seq_obuf #(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_load,
    input  logic [DW-1:0] i_data,
    input  logic          i_last,
    input  logic          i_ready,
    output logic          o_valid,
    output logic [DW-1:0] o_data,
    output logic          o_last,
    output logic          o_can_load
);

    logic          r_valid;
    logic [DW-1:0] r_data;
    logic          r_last;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_last  <= 1'b0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
            r_last  <= i_last;
        end else if (r_valid && i_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid    = r_valid;
    assign o_data     = r_data;
    assign o_last     = r_last;
    assign o_can_load = !r_valid || i_ready;

endmodule

// File: rtl/i2s_capture_seq.sv
// Capture sequencer: enables the I2S core, flushes its FIFO, optionally waits for
// voice activity, then pops samples into a valid/ready stream framed by count or hangover.
//
//  state | meaning
//  IDLE  | waiting for start
//  FLUSH | one-cycle FIFO flush, core disabled
//  ARM   | core enabled; VAD mode discards samples until vad_flag
//  CAPT  | popping samples into the stream
//  HANG  | popping samples after vad_flag fell, counting hangover
//  DRAIN | core disabled, waiting for the pending beat to be taken
//  DONE  | one-cycle completion pulse
module i2s_capture_seq #(
    parameter int CW = 16,
    parameter int HW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          stop,
    input  logic          mode,
    input  logic [CW-1:0] frame_len,
    input  logic [HW-1:0] hangover,
    output logic          i2s_en,
    output logic          fifo_flush,
    output logic          fifo_rd,
    input  logic          fifo_empty,
    input  logic          fifo_full,
    input  logic [31:0]   fifo_rdata,
    input  logic          vad_flag,
    output logic          m_valid,
    output logic [31:0]   m_data,
    output logic          m_last,
    input  logic          m_ready,
    output logic          busy,
    output logic          done,
    output logic          overrun,
    output logic          aborted
);
    import i2s_seq_pkg::*;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [CW-1:0] r_frame_len;
    logic [CW-1:0] r_cnt;
    logic [HW-1:0] r_hangover;
    logic [HW-1:0] r_hang_ctr;
    logic          r_mode;
    logic          r_last_sent;
    logic          r_overrun;
    logic          r_aborted;

    logic          w_accept;
    logic          w_stop_hit;
    logic          w_pop_state;
    logic          w_can_load;
    logic          w_pop;
    logic          w_discard;
    logic          w_last;
    logic [HW-1:0] w_hang_lim;

    assign w_accept    = (r_state == IDLE) && start && !stop && (frame_len != '0);
    assign w_stop_hit  = stop && (r_state inside {FLUSH, ARM, CAPT, HANG});
    assign w_pop_state = r_state inside {CAPT, HANG};
    // stop suppresses any pop in the same cycle so the abort leaves the FIFO untouched
    assign w_pop       = w_pop_state && !fifo_empty && w_can_load && !r_last_sent && !stop;
    assign w_discard   = (r_state == ARM) && (r_mode == MODE_VAD) && !vad_flag
                         && !fifo_empty && !stop;
    assign w_hang_lim  = (r_hangover == '0) ? HW'(1) : r_hangover;
    assign w_last      = (r_cnt + CW'(1) == r_frame_len)
                         || ((r_state == HANG) && (r_hang_ctr + HW'(1) == w_hang_lim));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:  if (w_accept) w_state_nxt = FLUSH;
            FLUSH: w_state_nxt = stop ? DRAIN : ARM;
            ARM: begin
                if (stop)                                  w_state_nxt = DRAIN;
                else if (r_mode == MODE_FIXED || vad_flag) w_state_nxt = CAPT;
            end
            CAPT: begin
                if (stop || (w_pop && w_last))               w_state_nxt = DRAIN;
                else if (r_mode == MODE_VAD && !vad_flag)    w_state_nxt = HANG;
            end
            HANG: begin
                if (stop || (w_pop && w_last)) w_state_nxt = DRAIN;
                else if (vad_flag)             w_state_nxt = CAPT;
            end
            DRAIN: if (w_can_load) w_state_nxt = DONE;
            DONE:  w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        i2s_en     = r_state inside {ARM, CAPT, HANG};
        fifo_flush = (r_state == FLUSH);
        fifo_rd    = w_pop || w_discard;
        busy       = (r_state != IDLE);
        done       = (r_state == DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_frame_len <= '0;
            r_hangover  <= '0;
            r_mode      <= MODE_FIXED;
            r_cnt       <= '0;
            r_hang_ctr  <= '0;
            r_last_sent <= 1'b0;
            r_overrun   <= 1'b0;
            r_aborted   <= 1'b0;
        end else if (w_accept) begin
            r_frame_len <= frame_len;
            r_hangover  <= hangover;
            r_mode      <= mode;
            r_cnt       <= '0;
            r_hang_ctr  <= '0;
            r_last_sent <= 1'b0;
            r_overrun   <= 1'b0;
            r_aborted   <= 1'b0;
        end else begin
            if (w_pop) begin
                r_cnt <= r_cnt + CW'(1);
                if (w_last) r_last_sent <= 1'b1;
            end
            // hangover counts only pops made after vad_flag fell
            if (r_state == CAPT) begin
                r_hang_ctr <= '0;
            end else if (r_state == HANG && w_pop) begin
                r_hang_ctr <= r_hang_ctr + HW'(1);
            end
            if (w_pop_state && fifo_full) r_overrun <= 1'b1;
            if (w_stop_hit)               r_aborted <= 1'b1;
        end
    end

    assign overrun = r_overrun;
    assign aborted = r_aborted;

    i2s_seq_obuf #(
        .DW(32)
    ) u_obuf (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_pop),
        .i_data     (fifo_rdata),
        .i_last     (w_last),
        .i_ready    (m_ready),
        .o_valid    (m_valid),
        .o_data     (m_data),
        .o_last     (m_last),
        .o_can_load (w_can_load)
    );

endmodule

// File: tb/tb_i2s_capture_seq.sv
// Scoreboard bench for i2s_capture_seq: a queue-based FIFO model feeds the DUT and a
// frame-level reference model predicts the captured stream.
module tb_i2s_capture_seq;
    import i2s_seq_pkg::*;

    localparam int CW = 16;
    localparam int HW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic          mode = 1'b0;
    logic [CW-1:0] frame_len = '0;
    logic [HW-1:0] hangover = '0;
    logic          i2s_en;
    logic          fifo_flush;
    logic          fifo_rd;
    logic          fifo_empty = 1'b1;
    logic          fifo_full = 1'b0;
    logic [31:0]   fifo_rdata = '0;
    logic          vad_flag = 1'b0;
    logic          m_valid;
    logic [31:0]   m_data;
    logic          m_last;
    logic          m_ready = 1'b0;
    logic          busy;
    logic          done;
    logic          overrun;
    logic          aborted;

    int n_checks = 0;
    int n_errors = 0;
    int pop_cnt = 0;
    int n_beats = 0;
    int ready_mode = 0;

    logic [31:0] fq[$];
    logic [31:0] push_req[$];
    logic [32:0] exp_q[$];

    logic        prev_stall = 1'b0;
    logic [32:0] prev_beat = '0;

    i2s_capture_seq #(.CW(CW), .HW(HW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .mode(mode),
        .frame_len(frame_len), .hangover(hangover), .i2s_en(i2s_en),
        .fifo_flush(fifo_flush), .fifo_rd(fifo_rd), .fifo_empty(fifo_empty),
        .fifo_full(fifo_full), .fifo_rdata(fifo_rdata), .vad_flag(vad_flag),
        .m_valid(m_valid), .m_data(m_data), .m_last(m_last), .m_ready(m_ready),
        .busy(busy), .done(done), .overrun(overrun), .aborted(aborted)
    );

    always #5 clk = ~clk;

    task automatic check(input bit ok, input string name, input logic [63:0] act,
                         input logic [63:0] req);
        n_checks++;
        if (!ok) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic chk_eq(input string name, input logic [63:0] act, input logic [63:0] req);
        check(act == req, name, act, req);
    endtask

    // FIFO model: first-word-fall-through queue, flushed/popped on the DUT strobes
    always @(posedge clk) begin
        if (fifo_flush) begin
            fq.delete();
        end else if (fifo_rd) begin
            check(fq.size() > 0, "rd_while_empty", 64'(fq.size()), 64'(1));
            if (fq.size() > 0) begin
                void'(fq.pop_front());
                pop_cnt++;
            end
        end
        while (push_req.size() > 0) fq.push_back(push_req.pop_front());
        fifo_empty <= (fq.size() == 0);
        fifo_rdata <= (fq.size() > 0) ? fq[0] : 32'h0;
    end

    always @(posedge clk) begin
        #2;
        case (ready_mode)
            0:       m_ready = ($urandom_range(0, 9) < 7);
            1:       m_ready = 1'b1;
            default: m_ready = 1'b0;
        endcase
    end

    // Monitor: pops the scoreboard on every accepted beat, checks hold during stalls
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk_eq("hold_valid", 64'(m_valid), 64'(1));
                chk_eq("hold_beat", 64'({m_last, m_data}), 64'(prev_beat));
            end
            if (m_valid && m_ready) begin
                n_beats++;
                if (exp_q.size() == 0) check(1'b0, "unexpected_beat", 64'({m_last, m_data}), 64'(0));
                else chk_eq("beat", 64'({m_last, m_data}), 64'(exp_q.pop_front()));
            end
            prev_stall = m_valid && !m_ready;
            prev_beat  = {m_last, m_data};
        end
    end

    function automatic logic [63:0] out_vec();
        return 64'({i2s_en, fifo_flush, fifo_rd, m_valid, m_data, m_last, busy, done,
                    overrun, aborted});
    endfunction

    task automatic start_capture(input logic md, input int fl, input int hv);
        mode = md;
        frame_len = CW'(fl);
        hangover = HW'(hv);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk_eq("flush_pulse", 64'({fifo_flush, i2s_en, busy}), 64'(3'b101));
        chk_eq("sticky_clear", 64'({overrun, aborted}), 64'(0));
        @(negedge clk);
        chk_eq("arm_en", 64'({fifo_flush, i2s_en}), 64'(2'b01));
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        #1;
        chk_eq("stop_no_pop", 64'(fifo_rd), 64'(0));
        @(negedge clk);
        stop = 1'b0;
    endtask

    task automatic wait_done(input int bound);
        int k = 0;
        while (!done && k < bound) begin
            @(negedge clk);
            k++;
        end
        check(done, "done_timeout", 64'(k), 64'(bound));
    endtask

    task automatic wait_fifo_drain(input int bound);
        int k = 0;
        while ((push_req.size() != 0 || fq.size() != 0) && k < bound) begin
            @(negedge clk);
            k++;
        end
        check(k < bound, "drain_timeout", 64'(k), 64'(bound));
    endtask

    task automatic finish_frame(input bit exp_abort);
        chk_eq("aborted", 64'(aborted), 64'(exp_abort));
        chk_eq("scoreboard_empty", 64'(exp_q.size()), 64'(0));
        @(negedge clk);
        chk_eq("idle", 64'({busy, i2s_en}), 64'(0));
    endtask

    // Fixed-length: the frame is the first frame_len words written after the flush
    task automatic run_fixed(input int fl, input int n);
        logic [31:0] w;
        start_capture(MODE_FIXED, fl, $urandom_range(0, 5));
        for (int i = 0; i < n; i++) begin
            w = $urandom;
            push_req.push_back(w);
            if (i < fl) exp_q.push_back({(i == fl - 1), w});
        end
        if (n < fl) begin
            wait_fifo_drain(400);
            pulse_stop();
        end
        wait_done(400);
        chk_eq("fifo_left", 64'(fq.size()), 64'((n >= fl) ? n - fl : 0));
        finish_frame(n < fl);
    endtask

    // VAD: vad_flag settles while the FIFO is empty, then one word is delivered
    task automatic run_vad(input int fl, input int hv, input bit vs[$]);
        bit started = 0;
        bit ended = 0;
        int cnt = 0;
        int hang = 0;
        int hl = (hv == 0) ? 1 : hv;
        bit lst;
        logic [31:0] w;
        start_capture(MODE_VAD, fl, hv);
        foreach (vs[i]) begin
            if (ended) break;
            vad_flag = vs[i];
            repeat (2) @(negedge clk);
            w = $urandom;
            if (started || vs[i]) begin
                started = 1;
                cnt++;
                hang = vs[i] ? 0 : hang + 1;
                lst = (cnt == fl) || (!vs[i] && hang == hl);
                exp_q.push_back({lst, w});
                ended = lst;
            end
            push_req.push_back(w);
            wait_fifo_drain(200);
        end
        if (!ended) pulse_stop();
        wait_done(400);
        vad_flag = 1'b0;
        finish_frame(!ended);
    endtask

    task automatic run_stop_mid();
        int pc0;
        int nb0;
        logic [31:0] w;
        ready_mode = 1;
        start_capture(MODE_FIXED, 60, 0);
        pc0 = pop_cnt;
        nb0 = n_beats;
        for (int i = 0; i < 40; i++) begin
            w = $urandom;
            push_req.push_back(w);
            exp_q.push_back({1'b0, w});
        end
        repeat ($urandom_range(3, 20)) @(negedge clk);
        pulse_stop();
        wait_done(200);
        chk_eq("beats_eq_pops", 64'(n_beats - nb0), 64'(pop_cnt - pc0));
        chk_eq("aborted_mid", 64'(aborted), 64'(1));
        exp_q.delete();
        ready_mode = 0;
        @(negedge clk);
    endtask

    task automatic wait_valid(input int bound);
        int k = 0;
        while (!m_valid && k < bound) begin
            @(negedge clk);
            k++;
        end
        check(m_valid, "valid_timeout", 64'(k), 64'(bound));
    endtask

    initial begin
        bit vs[$];
        logic [31:0] w0;

        repeat (3) @(negedge clk);
        chk_eq("reset_outputs", out_vec(), 64'(0));
        rst_n = 1'b1;
        @(negedge clk);

        frame_len = '0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk_eq("start_len0_ignored", 64'(busy), 64'(0));
        frame_len = 16'd4;
        start = 1'b1;
        stop = 1'b1;
        @(negedge clk);
        start = 1'b0;
        stop = 1'b0;
        chk_eq("start_stop_ignored", 64'(busy), 64'(0));

        run_fixed(4, 6);
        fifo_full = 1'b1;
        @(negedge clk);
        fifo_full = 1'b0;
        chk_eq("overrun_idle", 64'(overrun), 64'(0));
        run_fixed(3, 3);
        run_fixed(1, 2);
        run_fixed(5, 3);

        vs = '{0,0,0,0,0,0,0,0,0,0,1,1,1,1,1,0,0,0,0,0};
        run_vad(100, 2, vs);
        vs = '{0,0,1,1,1,0,1,1,0,0,0,0};
        run_vad(100, 3, vs);
        vs = '{1,1,0,0};
        run_vad(50, 0, vs);
        vs = '{1,1,1,0,0};
        run_vad(4, 2, vs);
        vs = '{0,0,0};
        run_vad(10, 1, vs);
        for (int r = 0; r < 8; r++) begin
            vs.delete();
            for (int i = 0; i < $urandom_range(4, 20); i++) vs.push_back($urandom_range(0, 2) != 0);
            run_vad($urandom_range(1, 12), $urandom_range(0, 4), vs);
        end

        // stalled stream, overrun pulse, then abort with a beat pending
        ready_mode = 2;
        start_capture(MODE_FIXED, 10, 0);
        for (int i = 0; i < 6; i++) push_req.push_back($urandom);
        w0 = push_req[0];
        exp_q.push_back({1'b0, w0});
        wait_valid(50);
        fifo_full = 1'b1;
        @(negedge clk);
        fifo_full = 1'b0;
        chk_eq("overrun_set", 64'(overrun), 64'(1));
        chk_eq("no_pop_stalled", 64'(fq.size()), 64'(5));
        pulse_stop();
        repeat (3) @(negedge clk);
        chk_eq("drain_pending", 64'({m_valid, m_last, busy, i2s_en}), 64'(4'b1010));
        ready_mode = 0;
        wait_done(200);
        chk_eq("no_pop_drain", 64'(fq.size()), 64'(5));
        chk_eq("overrun_sticky", 64'(overrun), 64'(1));
        finish_frame(1'b1);
        run_fixed(2, 4);

        for (int r = 0; r < 3; r++) run_stop_mid();

        // reset mid-capture
        ready_mode = 2;
        start_capture(MODE_FIXED, 10, 0);
        for (int i = 0; i < 4; i++) push_req.push_back($urandom);
        wait_valid(50);
        fifo_full = 1'b1;
        @(negedge clk);
        fifo_full = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        chk_eq("reset_mid_capt", out_vec(), 64'(0));
        exp_q.delete();
        rst_n = 1'b1;
        ready_mode = 0;
        @(negedge clk);
        run_fixed(3, 5);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
